// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - start/busy/done handshake and operand/result bundle for mul_seq
interface mul_seq_if #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
);
  logic                       start;
  logic [WIDTH_A-1:0]         A;
  logic [WIDTH_B-1:0]         B;
  logic                       busy;
  logic                       done;
  logic [WIDTH_A+WIDTH_B-1:0] P;
  logic [WIDTH_A-1:0]         Y;
  logic                       C_out;

  modport master (output start, A, B, input busy, done, P, Y, C_out);
  modport slave  (input start, A, B, output busy, done, P, Y, C_out);
endinterface

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-and-add unsigned multiplier, one multiplier bit per clock
// Optional MUL_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are all zero.
module mul_seq #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);
  localparam int WP = WIDTH_A + WIDTH_B;
  localparam int CW = ($clog2(WIDTH_B) < 1) ? 1 : $clog2(WIDTH_B);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WP-1:0]      mcand;
  logic [WP-1:0]      acc;
  logic [WP-1:0]      acc_nxt;
  logic [WP-1:0]      p_q;
  logic [WIDTH_B-1:0] mplier;
  logic [CW-1:0]      cnt;
  logic               last_step;
  logic               busy_c;
  logic               done_c;

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

`ifdef MUL_EARLY_TERM_EN
  assign last_step = (cnt == CW'(WIDTH_B - 1)) || ((mplier >> 1) == '0);
`else
  assign last_step = (cnt == CW'(WIDTH_B - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      CALC:    busy_c = 1'b1;
      DONE: begin
        busy_c = 1'b1;
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // The product register loads on the final step so it is already valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{WIDTH_B{1'b0}}, bus.A};
            mplier <= bus.B;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_step) p_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.P     = p_q;
  assign bus.Y     = p_q[WIDTH_A-1:0];
  assign bus.C_out = |p_q[WP-1:WIDTH_A];
endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard bench for mul_seq against an arithmetic reference model
module tb_mul_seq;
  localparam int WA = 4;
  localparam int WB = 4;
  localparam int WP = WA + WB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH_A(WA), .WIDTH_B(WB)) bus();

  mul_seq #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int p;
    int dcyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   held = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Number of CALC cycles the reference expects for a given multiplier.
  function automatic int calc_len(input logic [WB-1:0] b);
    int hi;
    hi = 0;
    for (int i = 0; i < WB; i++) if (b[i]) hi = i + 1;
`ifdef MUL_EARLY_TERM_EN
    return (hi < 1) ? 1 : hi;
`else
    return (hi < 0) ? 0 : WB;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_d;
      bit exp_b;
      exp_b = (q.size() > 0);
      exp_d = exp_b && (cyc == q[0].dcyc);
      check("busy", bus.busy, exp_b);
      check("done", bus.done, exp_d);
      if (exp_d) begin
        check("P", bus.P, q[0].p);
        check("Y", bus.Y, q[0].p % (1 << WA));
        check("C_out", bus.C_out, (q[0].p >= (1 << WA)) ? 1 : 0);
        held = q[0].p;
        void'(q.pop_front());
      end else begin
        check("P_hold", bus.P, held);
      end
    end
  end

  // mode 0: plain, 1: extra ignored start while busy, 2: reset in cycle 3
  task automatic do_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input int mode);
    exp_t e;
    int   len;
    int   used;
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    len = calc_len(b);
    e.p = int'(a) * int'(b);
    e.dcyc = cyc + len;
    q.push_back(e);
    bus.start = 1'b0;
    bus.A = WA'($urandom);
    bus.B = WB'($urandom);
    used = 0;
    if (mode == 1) begin
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.A = '1;
      bus.B = '1;
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b0;
      used = 4;
    end else if (mode == 2) begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_P", bus.P, 0);
      check("rst_Y", bus.Y, 0);
      check("rst_C_out", bus.C_out, 0);
      q.delete();
      held = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      return;
    end
    repeat (len + 1 - used) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    check("idle_P", bus.P, 0);
    check("idle_Y", bus.Y, 0);
    check("idle_C_out", bus.C_out, 0);

    do_op(4'hB, 4'hD, 0);
    repeat (2) @(posedge clk);
    #1;
    check("hold_P", bus.P, 8'h8F);
    do_op(4'h3, 4'h2, 0);
    do_op(4'hF, 4'hF, 0);
    do_op(4'h5, 4'h3, 1);
    do_op(4'h7, 4'h7, 2);
    do_op(4'h2, 4'h2, 0);
    do_op(4'hA, 4'h1, 0);
    do_op(4'h9, 4'h0, 0);
    do_op(4'h0, 4'h9, 0);
    do_op(4'h6, 4'h8, 0);
    for (int i = 0; i < 40; i++) begin
      do_op(WA'($urandom), WB'($urandom), 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("pending", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
